// File: rtl/hidden_cpu_sequencer.sv
// Program sequencer for the HiddenCPU core: buffers a loaded program,
// plays it into the core by PC, owns core reset, watchdog-limited runs.
module hidden_cpu_sequencer #(
   parameter int                   DEPTH      = 16,
   parameter int                   ADDR_W     = 4,
   parameter int                   INSTR_W    = 6,
   parameter logic [INSTR_W-1:0]   HOLD_INSTR = '0,
   parameter int                   MAX_CYCLES = 1000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_valid,
   input  logic [INSTR_W-1:0] load_data,
   output logic               load_ready,
   input  logic               start,
   input  logic               halt_req,
   input  logic               clear,
   input  logic [7:0]         core_pc,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic               core_rst,
   output logic [1:0]         state,
   output logic               timeout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_LOAD = 2'b01,
      S_RUN  = 2'b10,
      S_DONE = 2'b11
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [15:0]         cycles_q, cycles_d;
   logic                core_rst_q, core_rst_d;
   logic                timeout_q, timeout_d;
   logic [INSTR_W-1:0]  mem_q [DEPTH];

   logic                wr_en;
   logic                exec;
   logic                end_hit;
   logic                wd_fire;
   logic [8:0]          pc_ext;
   logic [8:0]          cnt_ext;

   assign pc_ext     = {1'b0, core_pc};
   assign cnt_ext    = 9'(count_q);
   assign load_ready = (state_q == S_IDLE || state_q == S_LOAD)
                       && (count_q < (ADDR_W+1)'(DEPTH));
   assign wr_en      = load_valid && load_ready;
   assign exec       = (state_q == S_RUN) && !core_rst_q;
   // PC compared at full width so an 8-bit PC never aliases into the buffer
   assign end_hit    = exec && (pc_ext >= cnt_ext);
   assign wd_fire    = exec && (cycles_q == 16'(MAX_CYCLES - 1));

   always_comb begin
      instr       = HOLD_INSTR;
      instr_valid = 1'b0;
      if (exec && !end_hit) begin
         instr       = mem_q[core_pc[ADDR_W-1:0]];
         instr_valid = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      cycles_d  = cycles_q;
      timeout_d = timeout_q;
      if (wr_en) count_d = count_q + 1'b1;
      unique case (state_q)
         S_IDLE: if (wr_en) state_d = S_LOAD;
         S_LOAD: if (start) state_d = S_RUN;
         S_RUN: begin
            if (halt_req || end_hit || wd_fire) state_d = S_DONE;
         end
         S_DONE: begin
            if (start) begin
               state_d = S_RUN;
            end else if (clear) begin
               state_d = S_IDLE;
               count_d = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (exec) cycles_d = cycles_q + 16'd1;
      if (wd_fire) timeout_d = 1'b1;
      if (state_d == S_RUN && state_q != S_RUN) begin
         cycles_d  = '0;
         timeout_d = 1'b0;
      end
      core_rst_d = (state_d == S_IDLE) || (state_d == S_LOAD)
                   || (state_d == S_RUN && state_q != S_RUN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         cycles_q   <= '0;
         core_rst_q <= 1'b1;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         cycles_q   <= cycles_d;
         core_rst_q <= core_rst_d;
         timeout_q  <= timeout_d;
      end
   end

   // Program storage survives reset; only the count is discarded
   always_ff @(posedge clk) begin
      if (wr_en && !rst) mem_q[count_q[ADDR_W-1:0]] <= load_data;
   end

   assign core_rst = core_rst_q;
   assign state    = state_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_hidden_cpu_sequencer.sv
// Scoreboard bench for hidden_cpu_sequencer: expected words queued as
// PCs are driven, popped when the sequencer presents a valid instruction.
module tb_hidden_cpu_sequencer;

   localparam logic [5:0] HOLD = 6'h00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_valid = 1'b0;
   logic [5:0] load_data = '0;
   logic       load_ready;
   logic       start = 1'b0;
   logic       halt_req = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] core_pc = '0;
   logic [5:0] instr;
   logic       instr_valid;
   logic       core_rst;
   logic [1:0] state;
   logic       timeout;

   int         n_chk = 0;
   int         n_err = 0;
   int         mcount = 0;
   logic [5:0] mprog [256];
   logic [5:0] sb [$];

   hidden_cpu_sequencer #(
      .DEPTH(16), .ADDR_W(4), .INSTR_W(6),
      .HOLD_INSTR(6'h00), .MAX_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready),
      .start(start), .halt_req(halt_req), .clear(clear),
      .core_pc(core_pc),
      .instr(instr), .instr_valid(instr_valid),
      .core_rst(core_rst), .state(state), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic load(input logic [5:0] w);
      load_valid = 1'b1;
      load_data  = w;
      #1;
      chk("load_ready", 32'(load_ready), 32'(mcount < 16));
      if (mcount < 16) begin
         mprog[mcount] = w;
         mcount++;
      end
      cyc();
      load_valid = 1'b0;
   endtask

   task automatic exec_pc(input int pc, input logic h);
      core_pc  = 8'(pc);
      halt_req = h;
      #1;
      chk("run_state", 32'(state), 32'd2);
      chk("exec_rst", 32'(core_rst), 32'd0);
      if (pc < mcount) sb.push_back(mprog[pc]);
      chk("valid", 32'(instr_valid), 32'(pc < mcount));
      if (instr_valid) begin
         if (sb.size() == 0) chk("sb_underflow", 32'(instr_valid), 32'd0);
         else chk("instr", 32'(instr), 32'(sb.pop_front()));
      end else begin
         chk("hold", 32'(instr), 32'(HOLD));
      end
      cyc();
      halt_req = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      cyc();
      start = 1'b0;
      #1;
      chk("entry_state", 32'(state), 32'd2);
      chk("entry_rst", 32'(core_rst), 32'd1);
      chk("entry_valid", 32'(instr_valid), 32'd0);
      chk("entry_tmo", 32'(timeout), 32'd0);
      cyc();
   endtask

   task automatic expect_done(input string tag, input logic tmo);
      #1;
      chk({tag, "_state"}, 32'(state), 32'd3);
      chk({tag, "_rst"}, 32'(core_rst), 32'd0);
      chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
      chk({tag, "_tmo"}, 32'(timeout), 32'(tmo));
      chk({tag, "_sb"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      mcount = 0;
      #1;
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_ready", 32'(load_ready), 32'd1);
   endtask

   initial begin
      cyc();
      cyc();
      #1;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_core", 32'(core_rst), 32'd1);
      chk("rst_tmo", 32'(timeout), 32'd0);
      chk("rst_instr", 32'(instr), 32'(HOLD));
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_ready", 32'(load_ready), 32'd1);
      rst = 1'b0;
      cyc();

      // basic program
      load(6'h01);
      #1 chk("load_state", 32'(state), 32'd1);
      chk("load_rst", 32'(core_rst), 32'd1);
      load(6'h02);
      load(6'h03);
      go();
      for (int i = 0; i < 4; i++) exec_pc(i, 1'b0);
      expect_done("end", 1'b0);

      // halt, then rerun same program
      go();
      exec_pc(0, 1'b0);
      exec_pc(1, 1'b1);
      expect_done("halt", 1'b0);
      go();
      exec_pc(0, 1'b0);
      exec_pc(1, 1'b1);
      expect_done("rerun", 1'b0);

      // watchdog with PC stuck at 0
      go();
      for (int i = 0; i < 8; i++) exec_pc(0, 1'b0);
      expect_done("wdog", 1'b1);
      go();
      exec_pc(2, 1'b1);
      expect_done("wdog_clr", 1'b0);

      // fill to depth, 17th word refused
      do_clear();
      for (int i = 0; i < 17; i++) load(6'(6'h10 + i));
      #1 chk("full_ready", 32'(load_ready), 32'd0);
      go();
      exec_pc(5, 1'b0);
      exec_pc(15, 1'b0);
      exec_pc(16, 1'b0);
      expect_done("full", 1'b0);

      // load and start in the same cycle
      do_clear();
      load(6'h11);
      load(6'h22);
      load_valid = 1'b1;
      load_data  = 6'h2A;
      start      = 1'b1;
      #1 chk("ls_ready", 32'(load_ready), 32'd1);
      mprog[mcount] = 6'h2A;
      mcount++;
      cyc();
      load_valid = 1'b0;
      start      = 1'b0;
      #1 chk("ls_state", 32'(state), 32'd2);
      chk("ls_rst", 32'(core_rst), 32'd1);
      chk("ls_ready2", 32'(load_ready), 32'd0);
      cyc();
      exec_pc(2, 1'b0);
      exec_pc(3, 1'b0);
      expect_done("ls", 1'b0);

      // reset mid-run loses the program count
      do_clear();
      for (int i = 0; i < 4; i++) load(6'(6'h30 + i));
      go();
      exec_pc(0, 1'b0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      mcount = 0;
      #1 chk("mid_state", 32'(state), 32'd0);
      chk("mid_core", 32'(core_rst), 32'd1);
      chk("mid_ready", 32'(load_ready), 32'd1);
      chk("mid_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < 4; i++) load(6'(6'h08 + i));
      go();
      exec_pc(3, 1'b0);
      exec_pc(8'hF0, 1'b0);
      expect_done("pcwrap", 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
